stop_watch_ctrl: RTL and testbench
==================================

Name: stop_watch_ctrl

Overview:
Control front-end for the 3-digit BCD stopwatch counter. It takes three raw push-buttons (start/stop, lap, clear), then synchronizes, debounces and edge-detects them. A run-control FSM drives the counter's go/clr inputs. A lap register freezes the displayed value while counting continues. Sits between the board buttons, the stopwatch counter and the hex display multiplexer.

Parameters:
DB_CNT_W, 20, debounce counter width; input must be stable 2^DB_CNT_W clk cycles (about 10.5 ms at 100 MHz); sim uses 3

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
btn  input  3  raw async buttons, active-high; [0]=start/stop, [1]=lap, [2]=clear
d2  input  4  live BCD digit 2 from counter
d1  input  4  live BCD digit 1
d0  input  4  live BCD digit 0
go  output  1  count enable to counter
clr  output  1  synchronous clear to counter
q2  output  4  BCD digit 2 to display
q1  output  4  BCD digit 1 to display
q0  output  4  BCD digit 0 to display
lap_led  output  1  high while the display is frozen (LAP)

Behaviour:
- Reset values while reset_n is low:
  - state=IDLE, go=0, clr=1, lap_led=0, lap register=0, all debounce levels=0, counters=0.
  - q follows d combinationally.
- clr deasserts at the first clk edge after reset_n rises. This gives the counter, which has no reset of its own, a guaranteed clear.
- Per button:
  - 2-FF synchronizer.
  - Debounce counter clears whenever the sync value equals the debounced level. Otherwise it increments.
  - At all-ones, the level flips and the counter clears.
  - Press pulse = 1 cycle on the rising edge of the level. Release produces no pulse.
- Latency from a stable pin change to the press pulse: 2 + 2^DB_CNT_W + 1 cycles. Holding a button produces exactly one pulse.
- Priority for pulses in the same cycle: clear > start/stop > lap. Lower-priority pulses in that cycle are dropped, not queued.
- FSM states: IDLE, RUN, PAUSE, LAP. Transitions:
  - IDLE: ss -> RUN; lap ignored; clear -> IDLE.
  - RUN: ss -> PAUSE; lap -> LAP and capture {d2,d1,d0} in the same cycle; clear -> IDLE.
  - LAP: ss -> PAUSE (display returns live); lap -> RUN (release freeze); clear -> IDLE.
  - PAUSE: ss -> RUN; lap ignored; clear -> IDLE.
- Any clear press, from any state including IDLE, gives clr=1 for exactly one cycle. It starts the cycle after the pulse.
- go = registered (state==RUN or LAP). It changes 1 cycle after the accepted pulse.
- lap_led = registered (state==LAP).
- Output mux: q = lap register when lap_led=1, else live d (combinational).
- Counter wrap from 9.9.9 is the counter's concern; no action here.
- Reset asserted mid-operation (any state, including mid-debounce) aborts immediately to the reset values.

Decomposition:
- Package stop_watch_pkg:
  - state enum (IDLE, RUN, PAUSE, LAP);
  - button index constants BTN_SS=0, BTN_LAP=1, BTN_CLR=2;
  - BCD digit width 4.
- Sub-module btn_debounce: synchronizer, debounce counter and rising-edge pulse, parameterized by DB_CNT_W. Instantiated 3 times.
- FSM, lap register and output mux live in the top.

Test Plan:
(All with DB_CNT_W=3, i.e. 8-cycle stability.)
1. Hold reset_n=0 with d=1/2/3 -> go=0, clr=1, lap_led=0, q=1/2/3. Release -> clr=0 after first edge, go stays 0.
2. btn[0] high for 15 cycles from IDLE -> exactly one press pulse 11 cycles after the pin edge. go=1 one cycle later and stays 1 after release.
3. btn[0] toggling every 3 cycles for 30 cycles -> no pulse, go unchanged, state unchanged.
4. RUN with d=3/4/5, press lap -> q=3/4/5 and lap_led=1 while d advances to 3/4/9, go stays 1. Press lap again -> q=3/4/9 (live), lap_led=0.
5. RUN, btn[0] and btn[2] pressed on the same edge -> state IDLE, go=0, one single-cycle clr pulse, start/stop dropped.
6. In LAP, pull reset_n low between clock edges -> go=0, lap_led=0, q=d immediately, clr=1. Clears on first edge after release.

Source files
------------

// File: rtl/stop_watch_pkg.sv
// Shared types and constants for the stopwatch control front-end.
package stop_watch_pkg;

  localparam int unsigned BCD_W   = 4;
  localparam int unsigned BTN_SS  = 0;
  localparam int unsigned BTN_LAP = 1;
  localparam int unsigned BTN_CLR = 2;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPause,
    StLap
  } sw_state_e;

  function automatic logic is_counting(input sw_state_e st);
    return (st == StRun) || (st == StLap);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter and a one-cycle press pulse
// on the rising edge of the debounced level.
module btn_debounce #(
  parameter int unsigned DB_CNT_W = 20
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic press_o
);

  logic [1:0]          sync_q;
  logic [DB_CNT_W-1:0] cnt_q, cnt_d;
  logic                level_q, level_d;
  logic                level_prev_q;
  logic                press_q;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q[1] != level_q) begin
      if (&cnt_q) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q       <= '0;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], btn_i};
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
      press_q      <= level_q & ~level_prev_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/stop_watch_ctrl.sv
// Stopwatch run control: conditions three buttons, drives counter go/clr and freezes
// the displayed value while in lap mode.
module stop_watch_ctrl
  import stop_watch_pkg::*;
#(
  parameter int unsigned DB_CNT_W = 20
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [2:0]       btn_i,
  input  logic [BCD_W-1:0] d2_i,
  input  logic [BCD_W-1:0] d1_i,
  input  logic [BCD_W-1:0] d0_i,
  output logic             go_o,
  output logic             clr_o,
  output logic [BCD_W-1:0] q2_o,
  output logic [BCD_W-1:0] q1_o,
  output logic [BCD_W-1:0] q0_o,
  output logic             lap_led_o
);

  logic [2:0] press;

  for (genvar i = 0; i < 3; i++) begin : g_btn
    btn_debounce #(
      .DB_CNT_W(DB_CNT_W)
    ) u_btn_debounce (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .btn_i  (btn_i[i]),
      .press_o(press[i])
    );
  end

  sw_state_e          state_q, state_d;
  logic               go_q, clr_q, lap_led_q;
  logic [3*BCD_W-1:0] lap_q;
  logic               lap_cap;

  // Clear outranks start/stop, which outranks lap; losers in the same cycle are dropped.
  always_comb begin
    state_d = state_q;
    lap_cap = 1'b0;
    if (press[BTN_CLR]) begin
      state_d = StIdle;
    end else if (press[BTN_SS]) begin
      unique case (state_q)
        StIdle:  state_d = StRun;
        StRun:   state_d = StPause;
        StLap:   state_d = StPause;
        StPause: state_d = StRun;
        default: state_d = StIdle;
      endcase
    end else if (press[BTN_LAP]) begin
      unique case (state_q)
        StRun: begin
          state_d = StLap;
          lap_cap = 1'b1;
        end
        StLap:   state_d = StRun;
        default: state_d = state_q;
      endcase
    end
  end

  // clr resets high so the counter, which has no reset, is cleared on the first edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      go_q      <= 1'b0;
      clr_q     <= 1'b1;
      lap_led_q <= 1'b0;
      lap_q     <= '0;
    end else begin
      state_q   <= state_d;
      go_q      <= is_counting(state_d);
      clr_q     <= press[BTN_CLR];
      lap_led_q <= (state_d == StLap);
      if (lap_cap) begin
        lap_q <= {d2_i, d1_i, d0_i};
      end
    end
  end

  assign go_o      = go_q;
  assign clr_o     = clr_q;
  assign lap_led_o = lap_led_q;

  always_comb begin
    if (lap_led_q) begin
      {q2_o, q1_o, q0_o} = lap_q;
    end else begin
      {q2_o, q1_o, q0_o} = {d2_i, d1_i, d0_i};
    end
  end

endmodule

// File: tb/tb_stop_watch_ctrl.sv
// Directed bench for stop_watch_ctrl with an 8-cycle debounce window.
module tb_stop_watch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  btn;
  logic [11:0] d_live;
  logic        go, clr, lap_led;
  logic [3:0]  q2, q1, q0;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned clr_hits;

  stop_watch_ctrl #(
    .DB_CNT_W(3)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .btn_i    (btn),
    .d2_i     (d_live[11:8]),
    .d1_i     (d_live[7:4]),
    .d0_i     (d_live[3:0]),
    .go_o     (go),
    .clr_o    (clr),
    .q2_o     (q2),
    .q1_o     (q1),
    .q0_o     (q0),
    .lap_led_o(lap_led)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hold long enough for one press pulse, then release and let the release settle.
  task automatic press(input int idx);
    btn[idx] = 1'b1;
    tick(15);
    btn[idx] = 1'b0;
    tick(14);
  endtask

  initial begin
    rst_n  = 1'b0;
    btn    = 3'b000;
    d_live = 12'h123;

    // Reset state
    tick(3);
    check("rst_go", go, 0);
    check("rst_clr", clr, 1);
    check("rst_lap_led", lap_led, 0);
    check("rst_q", {q2, q1, q0}, 12'h123);
    rst_n = 1'b1;
    #1;
    check("rel_clr_before_edge", clr, 1);
    tick(1);
    check("rel_clr_after_edge", clr, 0);
    check("rel_go", go, 0);
    tick(5);
    check("idle_go", go, 0);

    // Start/stop latency: pulse 11 edges after the pin change, go one edge later
    btn[0] = 1'b1;
    tick(11);
    check("ss_go_early", go, 0);
    tick(1);
    check("ss_go_set", go, 1);
    tick(3);
    btn[0] = 1'b0;
    tick(14);
    check("ss_hold_one_pulse", go, 1);
    check("ss_lap_led", lap_led, 0);

    // Bouncing input never settles: no state change
    for (int i = 0; i < 10; i++) begin
      btn[0] = ~btn[0];
      tick(3);
    end
    tick(12);
    check("bounce_go", go, 1);
    check("bounce_lap_led", lap_led, 0);

    // Lap freeze and release
    d_live = 12'h345;
    press(1);
    check("lap_led_on", lap_led, 1);
    check("lap_q_frozen", {q2, q1, q0}, 12'h345);
    check("lap_go", go, 1);
    d_live = 12'h349;
    tick(1);
    check("lap_q_holds", {q2, q1, q0}, 12'h345);
    press(1);
    check("lap_led_off", lap_led, 0);
    check("lap_q_live", {q2, q1, q0}, 12'h349);
    check("lap_go_after", go, 1);

    // Pause, lap ignored while paused, resume
    press(0);
    check("pause_go", go, 0);
    press(1);
    check("pause_lap_ignored_led", lap_led, 0);
    check("pause_lap_ignored_go", go, 0);
    press(0);
    check("resume_go", go, 1);

    // Start/stop and clear together: clear wins, single clr pulse
    btn = 3'b101;
    tick(11);
    check("both_clr_early", clr, 0);
    check("both_go_early", go, 1);
    tick(1);
    check("both_clr_pulse", clr, 1);
    check("both_go_cleared", go, 0);
    tick(1);
    check("both_clr_one_cycle", clr, 0);
    tick(2);
    btn      = 3'b000;
    clr_hits = 0;
    for (int i = 0; i < 14; i++) begin
      tick(1);
      if (clr) clr_hits++;
    end
    check("both_no_extra_clr", clr_hits, 0);
    check("both_ss_dropped", go, 0);

    // Clear from IDLE still pulses clr
    btn[2] = 1'b1;
    tick(12);
    check("idle_clr_pulse", clr, 1);
    check("idle_clr_go", go, 0);
    tick(1);
    check("idle_clr_end", clr, 0);
    tick(2);
    btn[2] = 1'b0;
    tick(14);

    // Async reset while in LAP
    press(0);
    d_live = 12'h345;
    press(1);
    check("lap2_led", lap_led, 1);
    d_live = 12'h678;
    #1;
    check("lap2_q_frozen", {q2, q1, q0}, 12'h345);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_go", go, 0);
    check("async_lap_led", lap_led, 0);
    check("async_clr", clr, 1);
    check("async_q_live", {q2, q1, q0}, 12'h678);
    tick(2);
    check("async_clr_held", clr, 1);
    rst_n = 1'b1;
    tick(1);
    check("async_rel_clr", clr, 0);
    check("async_rel_go", go, 0);
    check("async_rel_led", lap_led, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
